dm: RTL and testbench
=====================

Name: dm

Overview:
- 64-bit data memory for the MEM stage of the pipelined ARMv8 processor.
- Word-addressed array of DEPTH 64-bit entries.
- Write: synchronous, gated by MemWrite.
- Read: combinational, gated by MemRead.
- Synchronous reset clears the whole array to zero.

Parameters:
- DEPTH, 64, number of 64-bit words; power of two, at least 2.
- AW, log2(DEPTH) (6), internal index width. Derived; not overridable independently.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- reset  input  1  Synchronous, active-high. Clears memory on a rising clk edge while high.
- Address  input  64  Word index (not a byte address): Address=1 selects the second 64-bit word.
- DataWrite  input  64  Data stored when MemWrite=1.
- MemRead  input  1  Read enable.
- MemWrite  input  1  Write enable.
- DataRead  output  64  Read data.

Behaviour:
- Storage: mem[0..DEPTH-1], 64 bits each. No power-up value is guaranteed before the first reset.
- Reset:
  - Rising clk edge with reset=1 sets every mem entry to 0.
  - Reset has priority: a write requested in that cycle is discarded.
  - DataRead follows the read rule; after reset, any enabled read returns 0.
- Address decode:
  - In range when Address < DEPTH, i.e. Address[63:AW] == 0; index = Address[AW-1:0].
  - Out of range: writes are ignored (no aliasing/wrap); reads return 0.
- Write:
  - Rising clk edge with reset=0, MemWrite=1 and address in range: mem[index] <= DataWrite.
  - Full 64-bit write; no byte enables.
- Read (combinational, zero latency):
  - DataRead = mem[index] when MemRead=1 and address in range; otherwise 64'h0.
  - Reflects Address/MemRead changes within the same cycle, without waiting for a clock edge.
- Read-during-write, same address:
  - Before the edge, DataRead shows the old contents.
  - After the edge, DataRead shows the newly written value (no internal bypass).
- MemRead=1 and MemWrite=1 together are legal; read and write proceed independently as above.
- MemRead=0 and MemWrite=0: memory holds its contents; DataRead=0.
- No handshake and no stall: every access completes in one cycle.
- Data is unsigned raw bits; no sign/zero extension or size variants.
- Asserting reset mid-sequence wipes all previously written data from the next rising edge onward.

Test Plan:
1. Reset for 2 cycles, then MemRead=1 with Address=0 and Address=DEPTH-1 -> DataRead=0 for both.
2. Write Address=0 DataWrite=1, next cycle write Address=1 DataWrite=2, then MemWrite=0/MemRead=1 -> Address=0 reads 1; Address=1 reads 2; change Address with no clock edge -> DataRead updates combinationally.
3. Write 64'hDEADBEEF_CAFEF00D to Address=DEPTH-1, read back -> exact value; Address=0 still reads 1; MemRead=0 -> DataRead=0.
4. Same-cycle MemWrite=1/MemRead=1 at Address=5 with DataWrite=7, where mem[5] was 3 -> DataRead=3 before the edge, 7 after.
5. Write 9 to Address=DEPTH (out of range) -> mem[0] unchanged (reads 1); reading Address=DEPTH returns 0.
6. Assert reset concurrently with MemWrite=1, Address=2, DataWrite=5 -> afterwards all locations, including 0, 1 and 2, read 0.

Source files
------------

// File: rtl/dm_if.sv
// rtl/dm_if.sv - MEM-stage data memory bus interface
`timescale 1ns/1ps
interface dm_if;
  logic [63:0] Address;
  logic [63:0] DataWrite;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] DataRead;

  modport master (
    output Address,
    output DataWrite,
    output MemRead,
    output MemWrite,
    input  DataRead
  );

  modport slave (
    input  Address,
    input  DataWrite,
    input  MemRead,
    input  MemWrite,
    output DataRead
  );
endinterface

// File: rtl/dm.sv
// rtl/dm.sv - word-addressed 64-bit data memory, sync write, combinational read
`timescale 1ns/1ps
module dm #(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic reset,
  dm_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] index;
  logic          in_range;

  // Address is a word index; anything at or above DEPTH is rejected rather than wrapped.
  assign index    = bus.Address[AW-1:0];
  assign in_range = (bus.Address >> AW) == 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 64'd0;
      end
    end else if (bus.MemWrite && in_range) begin
      mem[index] <= bus.DataWrite;
    end
  end

  // No bypass: a same-cycle write becomes visible only after the edge.
  assign bus.DataRead = (bus.MemRead && in_range) ? mem[index] : 64'd0;
endmodule

// File: tb/tb_dm.sv
// tb/tb_dm.sv - directed self-checking bench for dm
`timescale 1ns/1ps
module tb_dm;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dm_if bus ();

  dm #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    bus.Address   = a;
    bus.DataWrite = d;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [63:0] a, input logic [63:0] exp);
    bus.Address = a;
    bus.MemRead = 1'b1;
    #1;
    check_eq(tag, bus.DataRead, exp);
  endtask

  initial begin
    reset         = 1'b1;
    bus.Address   = '0;
    bus.DataWrite = '0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    read_chk("rst_addr0", 64'd0, 64'd0);
    read_chk("rst_addr_last", 64'(DEPTH - 1), 64'd0);

    // basic writes and combinational read
    do_write(64'd0, 64'd1);
    do_write(64'd1, 64'd2);
    read_chk("rd_addr0", 64'd0, 64'd1);
    read_chk("rd_addr1_comb", 64'd1, 64'd2);

    // top word, isolation, read gating
    do_write(64'(DEPTH - 1), 64'hDEADBEEF_CAFEF00D);
    read_chk("rd_last", 64'(DEPTH - 1), 64'hDEADBEEF_CAFEF00D);
    read_chk("rd_addr0_kept", 64'd0, 64'd1);
    bus.MemRead = 1'b0;
    #1;
    check_eq("memread_off", bus.DataRead, 64'd0);

    // read-during-write at the same address
    do_write(64'd5, 64'd3);
    @(negedge clk);
    bus.Address   = 64'd5;
    bus.DataWrite = 64'd7;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    #1;
    check_eq("rdw_before", bus.DataRead, 64'd3);
    @(posedge clk);
    #1;
    check_eq("rdw_after", bus.DataRead, 64'd7);
    @(negedge clk);
    bus.MemWrite = 1'b0;

    // out-of-range write and read
    do_write(64'(DEPTH), 64'd9);
    do_write(64'h8000_0000_0000_0001, 64'd11);
    read_chk("oor_no_alias0", 64'd0, 64'd1);
    read_chk("oor_no_alias1", 64'd1, 64'd2);
    read_chk("oor_read", 64'(DEPTH), 64'd0);
    read_chk("oor_read_high", 64'h8000_0000_0000_0005, 64'd0);

    // reset beats a concurrent write
    do_write(64'd2, 64'd4);
    read_chk("pre_rst_addr2", 64'd2, 64'd4);
    @(negedge clk);
    reset         = 1'b1;
    bus.Address   = 64'd2;
    bus.DataWrite = 64'd5;
    bus.MemWrite  = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus.MemWrite = 1'b0;
    read_chk("post_rst_addr0", 64'd0, 64'd0);
    read_chk("post_rst_addr1", 64'd1, 64'd0);
    read_chk("post_rst_addr2", 64'd2, 64'd0);
    read_chk("post_rst_addr5", 64'd5, 64'd0);
    read_chk("post_rst_last", 64'(DEPTH - 1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
